// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - radix-2 iterative multiply/divide unit driving the HI/LO registers
// SIGNED_MD_EN selects two's-complement mult/div for op 10/11; otherwise op[1] is ignored.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [0:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               b_zero;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign busy = (state == S_RUN);

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        shifted = acc[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, opb};
        if (is_div) begin
            if (diff[WIDTH])
                acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {add_sum, acc[WIDTH-1:1]};
        end
    end

`ifdef SIGNED_MD_EN
    logic sign_a;
    logic sign_b;
    logic neg_res;
    logic neg_rem;

    assign sign_a = op[1] & a[WIDTH-1];
    assign sign_b = op[1] & b[WIDTH-1];
    assign mag_a  = sign_a ? -a : a;
    assign mag_b  = sign_b ? -b : b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (state == S_IDLE && start) begin
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
        end
    end

    // Remainder follows the dividend sign, so a zero divisor hands back the raw dividend
    always_comb begin
        prod = neg_res ? -acc_nxt : acc_nxt;
        quo  = neg_res ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
        rem  = neg_rem ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
    end
`else
    logic unused_op_sign;

    assign unused_op_sign = op[1];
    assign mag_a = a;
    assign mag_b = b;
    assign prod  = acc_nxt;
    assign quo   = acc_nxt[WIDTH-1:0];
    assign rem   = acc_nxt[2*WIDTH-1:WIDTH];
`endif

    assign res_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
    assign res_lo = is_div ? (b_zero ? '1 : quo) : prod[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            b_zero      <= 1'b0;
            opb         <= '0;
            acc         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_RUN;
                        cnt    <= '0;
                        is_div <= op[0];
                        b_zero <= (b == '0);
                        opb    <= op[0] ? mag_b : mag_a;
                        acc    <= {{WIDTH{1'b0}}, (op[0] ? mag_a : mag_b)};
                    end else begin
                        if (hi_we) hi <= wd;
                        if (lo_we) lo <= wd;
                    end
                end
                default: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state       <= S_IDLE;
                        hi          <= res_hi;
                        lo          <= res_lo;
                        done        <= 1'b1;
                        div_by_zero <= is_div & b_zero;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wd;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;
    int lat;
    int busy_cnt;
    int done_seen;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Launch one op and wait for done; lat counts edges from the start edge to done
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int l, output int bc);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        l  = 1;
        bc = 0;
        while (!done && l < 100) begin
            if (busy) bc++;
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic run_chk(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] ehi,
                           input logic [W-1:0] elo, input logic edz);
        run_op(o, x, y, lat, busy_cnt);
        chk({tag, "_lat"}, lat, 33);
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
        chk({tag, "_dz"}, {31'b0, div_by_zero}, {31'b0, edz});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_dz", {31'b0, div_by_zero}, 32'h0);

        // 1: multu with busy window and done pulse width
        run_chk("multu", 2'b00, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 1'b0);
        chk("multu_busy_cycles", busy_cnt, 32);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'b0, done}, 32'h0);

        run_chk("multu_big", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 32'h242D_2080, 1'b0);

        // 2: divu normal then divide by zero, dz clears next edge
        run_chk("divu", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_chk("divu_z", 2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        chk("dz_clear", {31'b0, div_by_zero}, 32'h0);
        run_chk("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 1'b0);

        // 3/4: signed ops (or their unsigned aliases)
`ifdef SIGNED_MD_EN
        run_chk("mult", 2'b10, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_chk("div", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_chk("div_minneg", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
`else
        run_chk("mult", 2'b10, 32'hFFFF_FFFD, 32'd5, 32'h4, 32'hFFFF_FFF1, 1'b0);
        run_chk("div", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC, 1'b0);
        run_chk("div_minneg", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0);
`endif
        run_chk("div_z", 2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

        // 5: start and hi_we while busy are ignored
        @(negedge clk);
        op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            start = (lat == 10);
            if (lat == 10) begin a = 32'd1; b = 32'd1; end
            hi_we = (lat == 12);
            wd = 32'hDEAD;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0; hi_we = 1'b0;
        chk("busy_ign_lat", lat, 33);
        chk("busy_ign_hi", hi, 32'd2);
        chk("busy_ign_lo", lo, 32'd14);
        @(negedge clk);
        hi_we = 1'b1; wd = 32'hDEAD;
        @(posedge clk); #1;
        hi_we = 1'b0;
        chk("mthi_hi", hi, 32'h0000_DEAD);
        chk("mthi_lo", lo, 32'd14);
        @(negedge clk);
        lo_we = 1'b1; wd = 32'hBEEF;
        @(posedge clk); #1;
        lo_we = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_BEEF);
        chk("mtlo_hi", hi, 32'h0000_DEAD);

        // 6: async reset mid-operation
        @(negedge clk);
        op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_hi", hi, 32'h0);
        chk("mid_rst_lo", lo, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("mid_rst_no_done", done_seen, 0);
        run_chk("after_rst", 2'b00, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
